pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipeline (fetcher -> decode1 -> alu -> datamemory -> writeback).
- Sequences the pipeline around:
  - instruction and data bus waits;
  - load-use hazards;
  - taken branches resolved in the MEM stage.
- Drives PC write-enable and redirect, per-stage hold/flush controls, EX operand forwarding selects, and saturating performance counters.

Parameters:
- XLEN, 64, PC/target width
- REG_W, 5, register index width
- FLUSH_CYCLES, 2, cycles of fetch discard after a redirect (0 = none; max 15)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_busy  in  1  fetcher awaiting instruction bus response
- mem_busy  in  1  datamemory awaiting data bus response
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID
- ex_rs, ex_rt  in  REG_W  source registers of the instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_destreg  in  REG_W  EX destination register
- mem_regwrite  in  1  MEM-stage regwrite
- mem_destreg  in  REG_W  MEM-stage destination register
- wb_regwrite  in  1  WB-stage regwrite
- wb_destreg  in  REG_W  WB-stage destination register
- branch_taken  in  1  MEM stage resolves a taken branch/jump
- branch_target  in  XLEN  redirect address
- pc_write  out  1  PC register update enable
- pc_sel  out  1  1 = load pc_target, 0 = pc+4
- pc_target  out  XLEN  redirect address
- pipe_en  out  1  global enable for ID/EX, EX/MEM, MEM/WB registers
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  zero IF/ID (bubble)
- id_ex_bubble  out  1  zero ID/EX control bits
- ex_mem_flush  out  1  zero EX/MEM control bits
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM result, 10 WB data
- stall_count  out  CNT_W  cycles with pc_write=0 since reset
- redirect_count  out  CNT_W  redirects issued since reset

Behaviour:
- FSM states: RUN, MEM_WAIT, FLUSH. Registers: state, pend_valid, pend_target, fl_cnt (4b), the two counters.
- Reset low, asynchronous:
  - state=RUN, pend cleared, fl_cnt=0, counters=0.
  - All outputs forced to pc_write=0, pipe_en=0, if_id_write=0, flushes/bubble=0, pc_sel=0, pc_target=0, fwd=00.
- Defaults, applied unless overridden: pc_write=1, pipe_en=1, if_id_write=1, everything else 0.
- RUN, evaluated in priority order:
  1. mem_busy: freeze (pc_write=0, pipe_en=0, if_id_write=0) -> MEM_WAIT. If branch_taken in the same cycle: pend_valid=1, pend_target=branch_target.
  2. branch_taken: pc_sel=1, pc_target=branch_target, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1. redirect_count++. If FLUSH_CYCLES>0, fl_cnt=FLUSH_CYCLES -> FLUSH.
  3. Load-use (ex_memread && ex_destreg!=0 && ex_destreg matches id_rs or id_rt): pc_write=0, if_id_write=0, id_ex_bubble=1. One cycle only, no state change.
  4. fetch_busy: pc_write=0, if_id_write=0, id_ex_bubble=1.
- MEM_WAIT:
  - While mem_busy: freeze. A branch_taken arriving while pend_valid=0 is captured; a later one is ignored.
  - When mem_busy=0:
    - pend_valid=1: perform the step-2 redirect using pend_target, clear pend, go to FLUSH (or RUN if FLUSH_CYCLES=0).
    - otherwise: default outputs, -> RUN.
- FLUSH:
  - if_id_flush=1, pc_write=1 (PC advances from the target); fl_cnt decrements.
  - Exit to RUN on the cycle fl_cnt reaches 1.
  - mem_busy freezes and holds fl_cnt.
  - A new branch_taken reloads fl_cnt and redirects again.
- Forwarding (combinational, independent of FSM; computed separately for rs->fwd_a and rt->fwd_b):
  - 01 if mem_regwrite && mem_destreg!=0 && mem_destreg==ex_rs/rt;
  - else 10 if the same condition holds for WB;
  - else 00.
  - MEM has priority over WB.
  - Register 0 never forwards.
- Counters saturate at all-ones and never wrap. stall_count increments on every non-reset cycle with pc_write=0.

Test Plan:
- Reset asserted mid-FLUSH (fl_cnt=2) -> immediately pc_write=0, state RUN, counters 0; first cycle after release pc_write=1.
- ex_memread=1, ex_destreg=5, id_rt=5 -> exactly 1 cycle of pc_write=0, id_ex_bubble=1; stall_count=1.
- branch_taken=1, target=0x1000, FLUSH_CYCLES=2 -> cycle 0: pc_sel=1, pc_target=0x1000, all three flushes; cycles 1-2: if_id_flush=1; cycle 3: RUN; redirect_count=1.
- mem_busy=1 for 4 cycles with branch_taken=1 in the first -> pipe_en=0 for 4 cycles; redirect to pend_target on the cycle mem_busy drops.
- mem_destreg=wb_destreg=7 (both regwrite), ex_rs=7 -> fwd_a=01; with ex_rt=0 and dest 0 -> fwd_b=00.
- Force stall_count to all-ones, hold fetch_busy=1 -> count stays all-ones.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall / flush / forwarding controller for the 5-stage pipeline
// (fetcher -> decode1 -> alu -> datamemory -> writeback).
//
// Control handshake: there is no valid/ready pair here. Every output is a
// per-cycle command that the pipeline obeys on the same rising clk edge.
// The fetcher and datamemory report back-pressure through fetch_busy and
// mem_busy, which are level signals sampled on every cycle.
//
// While reset is low, every command output is forced to its idle value.
// That means no PC update, no pipeline advance, and no flush.
module pipeline_hazard_ctrl #(
    parameter int XLEN         = 64,
    parameter int REG_W        = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,          // asynchronous, active-low
    input  logic             fetch_busy,
    input  logic             mem_busy,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_destreg,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_destreg,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_destreg,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    output logic             pc_write,
    output logic             pc_sel,
    output logic [XLEN-1:0]  pc_target,
    output logic             pipe_en,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] redirect_count,
    output logic [1:0]       dbg_state       // current FSM state, for observation
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam bit         HAS_FLUSH = (FLUSH_CYCLES > 0);
    localparam logic [3:0] FL_LOAD   = 4'(FLUSH_CYCLES);
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEM   = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;

    // Registered state
    state_t            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    logic [XLEN-1:0]   pend_target_q, pend_target_d;
    logic [3:0]        fl_cnt_q, fl_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  redir_cnt_q, redir_cnt_d;

    // Un-gated command values, produced by the FSM
    logic              pc_write_c;
    logic              pipe_en_c;
    logic              if_id_write_c;
    logic              if_id_flush_c;
    logic              id_ex_bubble_c;
    logic              ex_mem_flush_c;
    logic              pc_sel_c;
    logic [XLEN-1:0]   pc_target_c;
    logic [1:0]        fwd_a_c;
    logic [1:0]        fwd_b_c;

    // Redirect request, which is shared by all three states
    logic              do_redirect;
    logic [XLEN-1:0]   redirect_addr;

    // The load in EX writes a register that the instruction in ID reads.
    // Register 0 is hard-wired, so it never creates a dependency.
    logic load_use;
    assign load_use = ex_memread && (ex_destreg != '0) &&
                      ((ex_destreg == id_rs) || (ex_destreg == id_rt));

    // Next-state and command decode for the RUN / MEM_WAIT / FLUSH sequencer
    always_comb begin
        state_d        = state_q;
        pend_valid_d   = pend_valid_q;
        pend_target_d  = pend_target_q;
        fl_cnt_d       = fl_cnt_q;
        pc_write_c     = 1'b1;
        pipe_en_c      = 1'b1;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_mem_flush_c = 1'b0;
        do_redirect    = 1'b0;
        redirect_addr  = branch_target;

        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    // Data bus stall: freeze everything. A branch resolved
                    // under the stall is parked until memory releases.
                    pc_write_c    = 1'b0;
                    pipe_en_c     = 1'b0;
                    if_id_write_c = 1'b0;
                    state_d       = ST_MEM_WAIT;
                    if (branch_taken) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = branch_target;
                    end
                end else if (branch_taken) begin
                    do_redirect   = 1'b1;
                    redirect_addr = branch_target;
                    if (HAS_FLUSH) begin
                        fl_cnt_d = FL_LOAD;
                        state_d  = ST_FLUSH;
                    end
                end else if (load_use || fetch_busy) begin
                    // Hold PC and IF/ID, then inject a bubble into EX.
                    pc_write_c     = 1'b0;
                    if_id_write_c  = 1'b0;
                    id_ex_bubble_c = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    pc_write_c    = 1'b0;
                    pipe_en_c     = 1'b0;
                    if_id_write_c = 1'b0;
                    // Only the first branch seen under the stall is kept.
                    if (branch_taken && !pend_valid_q) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = branch_target;
                    end
                end else if (pend_valid_q) begin
                    do_redirect   = 1'b1;
                    redirect_addr = pend_target_q;
                    pend_valid_d  = 1'b0;
                    if (HAS_FLUSH) begin
                        fl_cnt_d = FL_LOAD;
                        state_d  = ST_FLUSH;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (mem_busy) begin
                    // Freeze. The discard count is held so that the
                    // wrong-path fetches are still covered after the stall.
                    pc_write_c    = 1'b0;
                    pipe_en_c     = 1'b0;
                    if_id_write_c = 1'b0;
                end else if (branch_taken) begin
                    do_redirect   = 1'b1;
                    redirect_addr = branch_target;
                    fl_cnt_d      = FL_LOAD;
                end else begin
                    // Discard the in-flight fetch while the PC advances
                    // from the target.
                    if_id_flush_c = 1'b1;
                    if (fl_cnt_q <= 4'd1) begin
                        fl_cnt_d = 4'd0;
                        state_d  = ST_RUN;
                    end else begin
                        fl_cnt_d = fl_cnt_q - 4'd1;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // A redirect loads the target and squashes the three younger stages.
        pc_sel_c    = do_redirect;
        pc_target_c = do_redirect ? redirect_addr : '0;
        if (do_redirect) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            ex_mem_flush_c = 1'b1;
        end
    end

    // EX operand forwarding. The MEM stage holds the newer value, so it wins over WB.
    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        if (mem_regwrite && (mem_destreg != '0) && (mem_destreg == ex_rs))
            fwd_a_c = FWD_MEM;
        else if (wb_regwrite && (wb_destreg != '0) && (wb_destreg == ex_rs))
            fwd_a_c = FWD_WB;
        if (mem_regwrite && (mem_destreg != '0) && (mem_destreg == ex_rt))
            fwd_b_c = FWD_MEM;
        else if (wb_regwrite && (wb_destreg != '0) && (wb_destreg == ex_rt))
            fwd_b_c = FWD_WB;
    end

    // Saturating performance counters: they hold at all-ones and never wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (!pc_write_c && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (do_redirect && (redir_cnt_q != '1))
            redir_cnt_d = redir_cnt_q + CNT_W'(1);
    end

    // State, pending-redirect, flush-count and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            fl_cnt_q      <= 4'd0;
            stall_cnt_q   <= '0;
            redir_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            fl_cnt_q      <= fl_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            redir_cnt_q   <= redir_cnt_d;
        end
    end

    // Gate the commands with reset so the pipeline stays parked while reset is low
    always_comb begin
        pc_write     = reset & pc_write_c;
        pipe_en      = reset & pipe_en_c;
        if_id_write  = reset & if_id_write_c;
        if_id_flush  = reset & if_id_flush_c;
        id_ex_bubble = reset & id_ex_bubble_c;
        ex_mem_flush = reset & ex_mem_flush_c;
        pc_sel       = reset & pc_sel_c;
        pc_target    = reset ? pc_target_c : '0;
        fwd_a        = reset ? fwd_a_c : FWD_RF;
        fwd_b        = reset ? fwd_b_c : FWD_RF;
    end

    assign stall_count    = stall_cnt_q;
    assign redirect_count = redir_cnt_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed vectors for the hazard controller. The driver sets the inputs
// just after each rising edge and queues the expected commands for that cycle.
// The monitor compares them on the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int XLEN  = 64;
  localparam int REG_W = 5;
  localparam int CNT_W = 8;
  localparam int EXP_W = 11 + XLEN + CNT_W + CNT_W;

  // ctrl = {pc_write, pc_sel, pipe_en, if_id_write, if_id_flush,
  //         id_ex_bubble, ex_mem_flush, fwd_a[1:0], fwd_b[1:0]}
  localparam logic [10:0] C_RST = 11'b0000000_0000;
  localparam logic [10:0] C_DEF = 11'b1011000_0000;
  localparam logic [10:0] C_FRZ = 11'b0000000_0000;
  localparam logic [10:0] C_STL = 11'b0010010_0000;
  localparam logic [10:0] C_RED = 11'b1111111_0000;
  localparam logic [10:0] C_FL  = 11'b1011100_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             fetch_busy, mem_busy, ex_memread, mem_regwrite, wb_regwrite, branch_taken;
  logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_destreg, mem_destreg, wb_destreg;
  logic [XLEN-1:0]  branch_target;
  logic             pc_write, pc_sel, pipe_en, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush;
  logic [XLEN-1:0]  pc_target;
  logic [1:0]       fwd_a, fwd_b, dbg_state;
  logic [CNT_W-1:0] stall_count, redirect_count;

  pipeline_hazard_ctrl #(
    .XLEN(XLEN), .REG_W(REG_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_busy(fetch_busy), .mem_busy(mem_busy),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_memread(ex_memread), .ex_destreg(ex_destreg),
    .mem_regwrite(mem_regwrite), .mem_destreg(mem_destreg),
    .wb_regwrite(wb_regwrite), .wb_destreg(wb_destreg),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_write(pc_write), .pc_sel(pc_sel), .pc_target(pc_target),
    .pipe_en(pipe_en), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .redirect_count(redirect_count),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string nm, input string what, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, what, act, exp);
    end
  endtask

  // monitor: one expected record per cycle, compared away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      string            nm;
      logic [10:0]      act_ctrl;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act_ctrl = {pc_write, pc_sel, pipe_en, if_id_write, if_id_flush,
                  id_ex_bubble, ex_mem_flush, fwd_a, fwd_b};
      check(nm, "ctrl", XLEN'(act_ctrl), XLEN'(e[EXP_W-1 -: 11]));
      check(nm, "pc_target", pc_target, e[2*CNT_W +: XLEN]);
      check(nm, "stall_count", XLEN'(stall_count), XLEN'(e[CNT_W +: CNT_W]));
      check(nm, "redirect_count", XLEN'(redirect_count), XLEN'(e[0 +: CNT_W]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic exp_cycle(input string nm, input logic [10:0] ctrl, input logic [XLEN-1:0] tgt,
                           input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] rc);
    exp_q.push_back({ctrl, tgt, sc, rc});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_busy = 0; mem_busy = 0; ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0;
    branch_taken = 0; id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_destreg = 0;
    mem_destreg = 0; wb_destreg = 0; branch_target = '0;
  endtask

  task automatic branch(input logic [XLEN-1:0] tgt);
    idle();
    branch_taken = 1; branch_target = tgt;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    reset = 0;
    @(posedge clk); #1;
    exp_cycle("reset_state", C_RST, 0, 0, 0);
    reset = 1;
    exp_cycle("idle_after_reset", C_DEF, 0, 0, 0);

    // load-use and fetch stalls
    ex_memread = 1; ex_destreg = 5; id_rt = 5;
    exp_cycle("load_use_rt", C_STL, 0, 0, 0);
    idle();
    exp_cycle("after_load_use", C_DEF, 0, 1, 0);
    ex_memread = 1; ex_destreg = 0; id_rs = 0;
    exp_cycle("load_use_r0", C_DEF, 0, 1, 0);
    idle(); ex_memread = 1; ex_destreg = 3; id_rs = 3; id_rt = 4;
    exp_cycle("load_use_rs", C_STL, 0, 1, 0);
    idle(); ex_destreg = 3; id_rs = 3;
    exp_cycle("no_load_no_stall", C_DEF, 0, 2, 0);
    idle(); fetch_busy = 1;
    exp_cycle("fetch_busy", C_STL, 0, 2, 0);

    // taken branch beats fetch_busy, then two discard cycles
    branch(64'h1000); fetch_busy = 1;
    exp_cycle("branch", C_RED, 64'h1000, 3, 0);
    idle();
    exp_cycle("flush1", C_FL, 0, 3, 1);
    exp_cycle("flush2", C_FL, 0, 3, 1);
    exp_cycle("run_after_flush", C_DEF, 0, 3, 1);

    // data bus wait with a branch parked in the first cycle
    branch(64'h2000); mem_busy = 1;
    exp_cycle("mem_busy1", C_FRZ, 0, 3, 1);
    branch_target = 64'h3000;
    exp_cycle("mem_busy2", C_FRZ, 0, 4, 1);
    branch_taken = 0;
    exp_cycle("mem_busy3", C_FRZ, 0, 5, 1);
    exp_cycle("mem_busy4", C_FRZ, 0, 6, 1);
    idle();
    exp_cycle("pend_redirect", C_RED, 64'h2000, 7, 1);
    exp_cycle("pend_flush1", C_FL, 0, 7, 2);
    exp_cycle("pend_flush2", C_FL, 0, 7, 2);
    exp_cycle("run_after_pend", C_DEF, 0, 7, 2);

    // mem_busy inside FLUSH holds the discard count
    branch(64'h4000);
    exp_cycle("branch2", C_RED, 64'h4000, 7, 2);
    idle();
    exp_cycle("flush_a", C_FL, 0, 7, 3);
    mem_busy = 1;
    exp_cycle("flush_freeze", C_FRZ, 0, 7, 3);
    idle();
    exp_cycle("flush_resume", C_FL, 0, 8, 3);
    exp_cycle("run_after_hold", C_DEF, 0, 8, 3);

    // a new branch inside FLUSH redirects again and reloads the count
    branch(64'h5000);
    exp_cycle("branch3", C_RED, 64'h5000, 8, 3);
    idle();
    exp_cycle("flush_b", C_FL, 0, 8, 4);
    branch(64'h6000);
    exp_cycle("rebranch", C_RED, 64'h6000, 8, 4);
    idle();
    exp_cycle("reflush1", C_FL, 0, 8, 5);
    exp_cycle("reflush2", C_FL, 0, 8, 5);
    exp_cycle("run_after_rebranch", C_DEF, 0, 8, 5);

    // forwarding
    mem_regwrite = 1; mem_destreg = 7; wb_regwrite = 1; wb_destreg = 7; ex_rs = 7; ex_rt = 0;
    exp_cycle("fwd_mem_prio", C_DEF | 11'b0100, 0, 8, 5);
    mem_regwrite = 0; ex_rt = 7;
    exp_cycle("fwd_wb", C_DEF | 11'b1010, 0, 8, 5);
    mem_regwrite = 1; mem_destreg = 0; wb_destreg = 0; ex_rs = 0; ex_rt = 0;
    exp_cycle("fwd_r0", C_DEF, 0, 8, 5);
    mem_destreg = 4; wb_destreg = 9; ex_rs = 9; ex_rt = 4;
    exp_cycle("fwd_split", C_DEF | 11'b1001, 0, 8, 5);
    mem_regwrite = 0; wb_regwrite = 0;
    exp_cycle("fwd_no_regwrite", C_DEF, 0, 8, 5);

    // reset asserted on the first FLUSH cycle (discard count still 2)
    branch(64'h7000);
    exp_cycle("branch4", C_RED, 64'h7000, 8, 5);
    idle();
    reset = 0;
    exp_cycle("reset_in_flush", C_RST, 0, 0, 0);
    reset = 1;
    exp_cycle("release_run", C_DEF, 0, 0, 0);
    exp_cycle("still_run", C_DEF, 0, 0, 0);

    // stall counter saturation
    fetch_busy = 1;
    for (int i = 0; i < 260; i++) begin
      logic [CNT_W-1:0] scv;
      scv = (i > 255) ? 8'hFF : 8'(i);
      exp_cycle("stall_sat", C_STL, 0, scv, 0);
    end
    idle();
    exp_cycle("sat_hold", C_DEF, 0, 8'hFF, 0);

    @(negedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
